// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable serial sequence detector with saturating match counter.
// Define SEQ_DET_MASK_EN to add a per-bit don't-care mask (mask_i) latched with the pattern.
module seq_det_prog #(
  parameter int SEQ_LEN = 4,
  parameter int CNT_W = 16,
  parameter logic [SEQ_LEN-1:0] DEFAULT_PATTERN = 4'b1011
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               data_i,
  input  logic [SEQ_LEN-1:0] pattern_i,
`ifdef SEQ_DET_MASK_EN
  input  logic [SEQ_LEN-1:0] mask_i,
`endif
  input  logic               pattern_ld_i,
  input  logic               overlap_i,
  input  logic               cnt_clr_i,
  output logic               detect_o,
  output logic [CNT_W-1:0]   match_cnt_o
);
  localparam int FW = $clog2(SEQ_LEN);
  localparam logic [FW-1:0] LAST = FW'(SEQ_LEN - 1);
  typedef enum logic {FILL, ARMED} state_t;
  state_t state_q, state_d;
  logic [SEQ_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [SEQ_LEN-1:0] pat_q, pat_d, mask_q, cand;
  logic [CNT_W-1:0] cnt_d;
  logic match;
`ifdef SEQ_DET_MASK_EN
  logic [SEQ_LEN-1:0] mask_d;
  always_ff @(posedge clk)
    mask_q <= rst ? '1 : mask_d;
  assign mask_d = pattern_ld_i ? mask_i : mask_q;
`else
  assign mask_q = '1;
`endif
  assign cand = {hist_q, data_i};
  assign match = valid_i && !pattern_ld_i && state_q == ARMED && ((cand ^ pat_q) & mask_q) == '0;
  always_comb begin
    state_d = state_q;
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d = pat_q;
    if (pattern_ld_i) begin
      pat_d = pattern_i;
      hist_d = '0;
      fill_d = '0;
    end else if (valid_i) begin
      hist_d = (match && !overlap_i) ? '0 : cand[SEQ_LEN-2:0];
      fill_d = (match && !overlap_i) ? '0 : (fill_q == LAST) ? LAST : fill_q + 1'b1;
    end
    state_d = (fill_d == LAST) ? ARMED : FILL;
    cnt_d = cnt_clr_i ? CNT_W'(match) : (match && match_cnt_o != '1) ? match_cnt_o + 1'b1 : match_cnt_o;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      hist_q <= '0;
      fill_q <= '0;
      pat_q <= DEFAULT_PATTERN;
      detect_o <= 1'b0;
      match_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q <= pat_d;
      detect_o <= match;
      match_cnt_o <= cnt_d;
    end
  end
endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: vector table plus hand-written sequences, checked through an expectation queue.
module tb_seq_det_prog;
  logic clk = 0, rst = 0, valid_i = 0, data_i = 0, pattern_ld_i = 0, overlap_i = 0, cnt_clr_i = 0;
  logic [3:0] pattern_i = 0;
  logic detect_o;
  logic [1:0] match_cnt_o;
  int nchk = 0, nfail = 0;
  typedef struct {logic r, v, d, l; logic [3:0] p; logic o, c, det; logic [1:0] cnt;} vec_t;
  typedef struct {logic det; logic [1:0] cnt; int id;} exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  always #5 clk = ~clk;
  seq_det_prog #(.SEQ_LEN(4), .CNT_W(2), .DEFAULT_PATTERN(4'b1011)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .pattern_i(pattern_i),
`ifdef SEQ_DET_MASK_EN
    .mask_i(4'b1111),
`endif
    .pattern_ld_i(pattern_ld_i), .overlap_i(overlap_i), .cnt_clr_i(cnt_clr_i),
    .detect_o(detect_o), .match_cnt_o(match_cnt_o));
  task automatic step(input logic r, v, d, l, input logic [3:0] p, input logic o, c, ed, input logic [1:0] ec, input int id);
    exp_t e;
    sb.push_back('{ed, ec, id});
    rst = r; valid_i = v; data_i = d; pattern_ld_i = l; pattern_i = p; overlap_i = o; cnt_clr_i = c;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    nchk += 2;
    if (detect_o !== e.det) begin
      nfail++;
      $display("FAIL det step %0d: got %b want %b", e.id, detect_o, e.det);
    end
    if (match_cnt_o !== e.cnt) begin
      nfail++;
      $display("FAIL cnt step %0d: got %0d want %0d", e.id, match_cnt_o, e.cnt);
    end
  endtask
  initial begin
    // r v d l pat o c det cnt
    tbl.push_back('{1,0,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,1,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,1,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,1,0,4'h0,1,0,1,2'd1});
    tbl.push_back('{0,1,0,0,4'h0,1,0,0,2'd1});
    tbl.push_back('{0,1,1,0,4'h0,1,0,0,2'd1});
    tbl.push_back('{0,1,1,0,4'h0,1,0,1,2'd2});
    tbl.push_back('{1,0,0,0,4'h0,0,0,0,2'd0});
    tbl.push_back('{0,1,1,0,4'h0,0,0,0,2'd0});
    tbl.push_back('{0,1,0,0,4'h0,0,0,0,2'd0});
    tbl.push_back('{0,1,1,0,4'h0,0,0,0,2'd0});
    tbl.push_back('{0,1,1,0,4'h0,0,0,1,2'd1});
    tbl.push_back('{0,1,0,0,4'h0,0,0,0,2'd1});
    tbl.push_back('{0,1,1,0,4'h0,0,0,0,2'd1});
    tbl.push_back('{0,1,1,0,4'h0,0,0,0,2'd1});
    tbl.push_back('{1,0,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,1,1,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,0,0,4'h0,1,0,1,2'd1});
    tbl.push_back('{0,1,0,0,4'h0,1,0,1,2'd2});
    tbl.push_back('{0,0,0,0,4'h0,1,0,0,2'd2});
    tbl.push_back('{1,0,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,1,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,0,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,0,1,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,0,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,0,1,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,0,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,0,1,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,1,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,0,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,0,1,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,0,0,0,4'h0,1,0,0,2'd0});
    tbl.push_back('{0,1,1,0,4'h0,1,0,1,2'd1});
    tbl.push_back('{0,1,0,1,4'h6,1,0,0,2'd1});
    tbl.push_back('{0,1,1,0,4'h0,1,0,0,2'd1});
    tbl.push_back('{0,1,0,0,4'h0,1,0,0,2'd1});
    tbl.push_back('{0,1,0,0,4'h0,1,0,0,2'd1});
    tbl.push_back('{0,1,1,0,4'h0,1,0,0,2'd1});
    tbl.push_back('{0,1,1,0,4'h0,1,0,0,2'd1});
    tbl.push_back('{0,1,0,0,4'h0,1,0,1,2'd2});
    foreach (tbl[i]) step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].p, tbl[i].o, tbl[i].c, tbl[i].det, tbl[i].cnt, i);
    // counter saturation, then clear coincident with a match, then clear alone
    step(1,0,0,0,4'h0,1,0,0,2'd0,100);
    step(0,0,0,1,4'h0,1,0,0,2'd0,101);
    for (int i = 0; i < 3; i++) step(0,1,0,0,4'h0,1,0,0,2'd0,102 + i);
    for (int i = 1; i <= 5; i++) step(0,1,0,0,4'h0,1,0,1,(i > 3) ? 2'd3 : 2'(i),104 + i);
    step(0,1,0,0,4'h0,1,1,1,2'd1,110);
    step(0,0,0,0,4'h0,1,1,0,2'd0,111);
    // reset mid-stream wins over a bit that would otherwise complete 1011
    step(1,0,0,0,4'h0,1,0,0,2'd0,200);
    step(0,1,1,0,4'h0,1,0,0,2'd0,201);
    step(0,1,0,0,4'h0,1,0,0,2'd0,202);
    step(0,1,1,0,4'h0,1,0,0,2'd0,203);
    step(0,1,1,0,4'h0,1,0,1,2'd1,204);
    step(0,1,1,0,4'h0,1,0,0,2'd1,205);
    step(0,1,0,0,4'h0,1,0,0,2'd1,206);
    step(0,1,1,0,4'h0,1,0,0,2'd1,207);
    step(1,1,1,0,4'h0,1,0,0,2'd0,208);
    step(0,1,1,0,4'h0,1,0,0,2'd0,209);
    step(0,1,1,0,4'h0,1,0,0,2'd0,210);
    step(0,1,0,0,4'h0,1,0,0,2'd0,211);
    step(0,1,1,0,4'h0,1,0,0,2'd0,212);
    step(0,1,1,0,4'h0,1,0,1,2'd1,213);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
Parametrised, runtime-programmable serial sequence detector; successor to the fixed 4-bit seq_det.
- Adds configurable pattern length, runtime pattern load, input-valid qualification, overlap/non-overlap mode, and a saturating match counter.
- Sits on a 1-bit serial data stream and flags each complete occurrence of the programmed pattern to downstream control/statistics logic.

Parameters:
SEQ_LEN, 4, pattern length in bits (>=2).
CNT_W, 16, width of the match counter.
DEFAULT_PATTERN, 4'b1011, pattern loaded at reset (SEQ_LEN bits). Bit SEQ_LEN-1 is the first bit in time; bit 0 is the last.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous active-high reset.
valid_i  in  1  data_i is sampled only when high.
data_i  in  1  serial data bit.
pattern_i  in  SEQ_LEN  new pattern value.
pattern_ld_i  in  1  load pattern_i into the pattern register.
overlap_i  in  1  1 = overlapping matches allowed; 0 = history restarts after a match.
cnt_clr_i  in  1  clear the match counter.
detect_o  out  1  one-cycle match pulse (registered).
match_cnt_o  out  CNT_W  number of matches, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - pattern reg = DEFAULT_PATTERN; history = 0; fill count = 0.
  - detect_o = 0; match_cnt_o = 0.
  - rst has priority over every other input.
- Priority per edge: rst > pattern_ld_i > valid_i. cnt_clr_i is handled independently (see below).
- History is a SEQ_LEN-1 bit shift register. Fill count is 0..SEQ_LEN-1 and saturates at SEQ_LEN-1.
- Two states:
  - FILL: fill count < SEQ_LEN-1.
  - ARMED: fill count = SEQ_LEN-1.
- On an edge with valid_i=1 and pattern_ld_i=0:
  - Candidate = {history, data_i}.
  - Match = (state==ARMED) and (candidate == pattern reg).
  - History shifts: history <= candidate[SEQ_LEN-2:0].
  - Fill count increments, saturating at SEQ_LEN-1.
- On a match:
  - detect_o = 1 for exactly the following cycle. Latency is one clock after the edge that samples the last pattern bit.
  - If overlap_i=1 at that edge: history keeps shifting; the state stays ARMED.
  - If overlap_i=0 at that edge: history <= 0 and fill count <= 0, returning to FILL. No bit of the matched sequence is reused.
- valid_i=0: history, fill count and state are held; detect_o = 0 that cycle; data_i is ignored.
- pattern_ld_i=1:
  - Pattern reg <= pattern_i; history <= 0; fill count <= 0.
  - detect_o = 0; data_i on that edge is discarded.
  - Counter is unaffected.
- Matches are never declared from reset-zero history. At least SEQ_LEN valid bits are required after reset, a load, or a non-overlap match.
- Counter:
  - Increments by 1 per match and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr_i=1 with no match: counter <= 0.
  - cnt_clr_i=1 with a simultaneous match: counter <= 1.
- overlap_i is sampled per edge only; changing it mid-stream does not clear history.

Optional Feature:
SEQ_DET_MASK_EN
- Defined:
  - Adds input port mask_i [SEQ_LEN-1:0], latched together with pattern_i on pattern_ld_i. Reset value is all-ones.
  - A mask bit of 0 makes that pattern position don't-care: the compare is ((candidate ^ pattern) & mask) == 0.
- Not defined:
  - Port mask_i is absent; the compare is exact equality.
  - Behaviour is identical to the defined case with mask all-ones.

Test Plan:
1. Defaults, overlap_i=1, valid bits 1,0,1,1,0,1,1 -> detect_o pulses after the 4th and 7th bits; match_cnt_o=2.
2. Same stream with overlap_i=0 -> a single pulse after the 4th bit; match_cnt_o=1.
3. Pattern 0000 loaded, then valid bits 0,0,0 -> no detect (FILL); 4th 0 -> detect; 5th 0 with overlap=1 -> detect again; count=2.
4. Stream 1,0,1 with valid_i=0 gaps of 3 cycles between bits and data_i toggling during the gaps, then 1 -> exactly one detect; count=1. Then pattern_ld_i with 0110 followed by bits 1,0 -> no detect; then 0,1,1,0 -> detect.
5. CNT_W=2, 5 matches -> match_cnt_o=3 (saturated). cnt_clr_i coincident with a 6th match -> match_cnt_o=1.
6. rst=1 asserted mid-stream after 1,0,1 -> next cycle detect_o=0, count=0, pattern reverts to 1011. A following 1 alone gives no detect; 1,0,1,1 gives a detect.
